lcd_nibble_writer: RTL and testbench

Byte-to-nibble HD44780 write engine that drives the character LCD in 4-bit mode. It sits directly downstream of the clock/timekeeping logic: that logic formats digits and commands into bytes, and this block owns the LCD pins. It performs the power-on nibble initialisation, then accepts one byte per valid/ready handshake and emits it as two timed enable strobes. All LCD pin timing lives here, so upstream never counts cycles.

---
 rtl/lcd_pkg.sv | 42 ++++
 rtl/lcd_delay_timer.sv | 26 ++
 rtl/lcd_nibble_writer.sv | 172 +++++++++++++++++
 tb/tb_lcd_nibble_writer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit write engine and its upstream
// command formatter.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        HI,
        LO,
        LONG
    } lcd_state_t;

    // Position inside one nibble transfer: setup, enable pulse, enable-low hold.
    typedef enum logic [1:0] {
        PH_SETUP,
        PH_EN,
        PH_GAP
    } nib_phase_t;

    localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Configuration bytes the upstream formatter sends right after init_done.
    localparam logic [7:0] CFG_FUNCTION_SET = 8'h28;
    localparam logic [7:0] CFG_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] CFG_ENTRY_MODE   = 8'h06;
    localparam logic [7:0] CFG_CLEAR        = 8'h01;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear and home need extra execution time; character data never does.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; done is high while the count sits at zero, and the count
// parks there instead of wrapping.
module lcd_delay_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count;

    // NOTE: no reset branch; the owner holds load high during its reset, so the
    // count is always defined after the first reset edge.
    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit write engine: power-on nibble init, then one byte per handshake
// sent as two timed enable strobes.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES  = 600000,
    parameter int INIT_GAP_CYCLES = 60000,
    parameter int EN_CYCLES       = 800,
    parameter int GAP_CYCLES      = 800,
    parameter int LONG_CYCLES     = 24000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [3:0] lcd_data
);

    localparam int MAX_CYC = max_of(max_of(max_of(POWERUP_CYCLES, INIT_GAP_CYCLES),
                                           max_of(EN_CYCLES, GAP_CYCLES)), LONG_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // A phase of N cycles loads N-1 and ends on the edge where the count is zero.
    localparam logic [CNT_W-1:0] LD_PWR      = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_INIT_GAP = CNT_W'(INIT_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_EN       = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_GAP      = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_LONG     = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_SETUP    = '0;

    lcd_state_t state, state_n;
    nib_phase_t phase, phase_n;
    logic [1:0] init_idx, init_idx_n;
    logic [7:0] byte_q, byte_n;
    logic       rs_q, rs_n;
    logic       lcd_rs_n, lcd_en_n, in_ready_n, init_done_n;
    logic [3:0] lcd_data_n;

    logic             load;
    logic [CNT_W-1:0] load_value;
    logic             done;

    lcd_delay_timer #(.W(CNT_W)) u_timer (
        .clk       (clk),
        .load      (load),
        .load_value(load_value),
        .done      (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWR_WAIT;
            phase     <= PH_SETUP;
            init_idx  <= '0;
            byte_q    <= '0;
            rs_q      <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_data  <= '0;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            init_idx  <= init_idx_n;
            byte_q    <= byte_n;
            rs_q      <= rs_n;
            lcd_rs    <= lcd_rs_n;
            lcd_en    <= lcd_en_n;
            lcd_data  <= lcd_data_n;
            in_ready  <= in_ready_n;
            init_done <= init_done_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n     = state;
        phase_n     = phase;
        init_idx_n  = init_idx;
        byte_n      = byte_q;
        rs_n        = rs_q;
        lcd_rs_n    = lcd_rs;
        lcd_en_n    = lcd_en;
        lcd_data_n  = lcd_data;
        in_ready_n  = in_ready;
        init_done_n = init_done;
        load        = 1'b0;
        load_value  = LD_SETUP;

        unique case (state)
            PWR_WAIT: if (done) begin
                state_n    = INIT;
                init_idx_n = '0;
                lcd_data_n = INIT_NIB_WAKE;
                lcd_rs_n   = 1'b0;
                phase_n    = PH_SETUP;
                load       = 1'b1;
            end
            IDLE: if (in_valid && in_ready) begin
                state_n    = HI;
                byte_n     = in_data;
                rs_n       = in_rs;
                in_ready_n = 1'b0;
                lcd_data_n = in_data[7:4];
                lcd_rs_n   = in_rs;
                phase_n    = PH_SETUP;
                load       = 1'b1;
            end
            LONG: if (done) begin
                state_n    = IDLE;
                in_ready_n = 1'b1;
            end
            INIT, HI, LO: if (done) begin
                unique case (phase)
                    PH_SETUP: begin
                        lcd_en_n   = 1'b1;
                        phase_n    = PH_EN;
                        load       = 1'b1;
                        load_value = LD_EN;
                    end
                    PH_EN: begin
                        lcd_en_n   = 1'b0;
                        phase_n    = PH_GAP;
                        load       = 1'b1;
                        // The first two wake-up nibbles need the long init settle time.
                        load_value = (state == INIT && init_idx < 2'd2) ? LD_INIT_GAP : LD_GAP;
                    end
                    PH_GAP: begin
                        phase_n = PH_SETUP;
                        if (state == INIT) begin
                            if (init_idx == 2'd3) begin
                                state_n     = IDLE;
                                in_ready_n  = 1'b1;
                                init_done_n = 1'b1;
                            end else begin
                                init_idx_n = init_idx + 2'd1;
                                lcd_data_n = (init_idx == 2'd2) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
                                load       = 1'b1;
                            end
                        end else if (state == HI) begin
                            state_n    = LO;
                            lcd_data_n = byte_q[3:0];
                            lcd_rs_n   = rs_q;
                            load       = 1'b1;
                        end else if (is_long_cmd(rs_q, byte_q)) begin
                            state_n    = LONG;
                            load       = 1'b1;
                            load_value = LD_LONG;
                        end else begin
                            state_n    = IDLE;
                            in_ready_n = 1'b1;
                        end
                    end
                    default: phase_n = PH_SETUP;
                endcase
            end
            default: state_n = PWR_WAIT;
        endcase

        if (rst) begin
            load       = 1'b1;
            load_value = LD_PWR;
        end
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Randomized scoreboard bench: the driver queues the nibbles each byte should
// produce, and a pin monitor pops and checks them on every enable strobe.
module tb_lcd_nibble_writer;

    localparam int P_PWR  = 100;
    localparam int P_IGAP = 20;
    localparam int P_EN   = 4;
    localparam int P_GAP  = 4;
    localparam int P_LONG = 50;

    localparam int BYTE_CYC = 2 * (1 + P_EN + P_GAP);
    localparam int INIT_CYC = P_PWR + 4 + 4 * P_EN + 2 * P_IGAP + 2 * P_GAP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_en;
    logic [3:0] lcd_data;

    lcd_nibble_writer #(
        .POWERUP_CYCLES (P_PWR),
        .INIT_GAP_CYCLES(P_IGAP),
        .EN_CYCLES      (P_EN),
        .GAP_CYCLES     (P_GAP),
        .LONG_CYCLES    (P_LONG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rs    (in_rs),
        .in_data  (in_data),
        .init_done(init_done),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en),
        .lcd_data (lcd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected nibble stream, {rs, nibble}, in the order the pins must show it.
    logic [4:0] exp_q[$];

    logic       prev_en = 1'b0;
    logic       prev_rs = 1'b0;
    logic [3:0] prev_data = 4'h0;
    logic [4:0] rise_val = 5'h0;
    logic [4:0] exp_nib;
    int         en_w = 0;

    always @(negedge clk) begin
        if (rst) begin
            en_w = 0;
        end else begin
            if (lcd_en && !prev_en) begin
                check("setup_before_en", int'({prev_rs, prev_data}), int'({lcd_rs, lcd_data}));
                rise_val = {lcd_rs, lcd_data};
                if (exp_q.size() == 0) begin
                    check("unexpected_nibble_queue", exp_q.size(), 1);
                end else begin
                    exp_nib = exp_q.pop_front();
                    check("nibble_rs_data", int'({lcd_rs, lcd_data}), int'(exp_nib));
                end
            end
            if (lcd_en) en_w++;
            if (!lcd_en && prev_en) begin
                check("en_width", en_w, P_EN);
                check("hold_across_en", int'({lcd_rs, lcd_data}), int'(rise_val));
                en_w = 0;
            end
        end
        prev_en   = rst ? 1'b0 : lcd_en;
        prev_rs   = lcd_rs;
        prev_data = lcd_data;
    end

    int         acc_cyc   = 0;
    int         ready_cyc = 0;
    int         exp_wait  = 0;
    logic [7:0] cur_d     = 8'h00;
    logic       cur_rs    = 1'b0;

    // Called just after a posedge; asserts reset, checks pin reset values and the init timing.
    task automatic do_reset();
        int n;
        int rel;
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b0, 4'h2});
        @(posedge clk);
        @(negedge clk);
        check("rst_lcd_en", int'(lcd_en), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_lcd_rs", int'(lcd_rs), 0);
        check("rst_lcd_data", int'(lcd_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rel = cyc;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("init_ready_cycles", cyc - rel, INIT_CYC);
        check("init_done_set", int'(init_done), 1);
        check("init_nibbles_consumed", exp_q.size(), 0);
        ready_cyc = cyc;
    endtask

    task automatic accept(input logic rs, input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", int'(in_ready), 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        cur_d   = d;
        cur_rs  = rs;
        exp_q.push_back({rs, d[7:4]});
        exp_q.push_back({rs, d[3:0]});
        exp_wait = BYTE_CYC + ((!rs && (d == 8'h01 || d == 8'h02)) ? P_LONG : 0);
    endtask

    task automatic finish_byte(input bit disturb);
        int n;
        n = 0;
        @(negedge clk);
        check("first_pin_latency", int'(lcd_data), int'(cur_d[7:4]));
        check("first_pin_rs", int'(lcd_rs), int'(cur_rs));
        check("ready_drop", int'(in_ready), 0);
        while (!in_ready && n < 5000) begin
            if (disturb) begin
                if (n >= 2 && n < 8) begin
                    in_valid = n[0];
                    in_data  = 8'($urandom);
                    in_rs    = ~cur_rs;
                end else if (n == 8) begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            n++;
        end
        check("ready_return_cycles", cyc - acc_cyc, exp_wait);
        ready_cyc = cyc;
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input bit disturb);
        accept(rs, d);
        in_valid = 1'b0;
        finish_byte(disturb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       r;
        logic [7:0] d;

        @(posedge clk);
        #1;
        do_reset();

        send(1'b1, 8'h35, 1'b0);
        send(1'b0, 8'h01, 1'b0);
        send(1'b1, 8'h01, 1'b0);
        send(1'b0, 8'h02, 1'b0);
        send(1'b1, 8'h02, 1'b0);
        send(1'b0, 8'h28, 1'b0);

        // Back-to-back with in_valid held high throughout.
        accept(1'b1, 8'h31);
        in_data = 8'h32;
        finish_byte(1'b0);
        accept(1'b1, 8'h32);
        check("b2b_accept_on_first_ready", acc_cyc - ready_cyc, 1);
        in_data = 8'h3A;
        finish_byte(1'b0);
        accept(1'b1, 8'h3A);
        check("b2b_accept_on_first_ready", acc_cyc - ready_cyc, 1);
        in_valid = 1'b0;
        finish_byte(1'b0);
        repeat (3) @(negedge clk);
        check("b2b_no_extra_transfer", exp_q.size(), 0);
        check("b2b_ready_idle", int'(in_ready), 1);

        // Inputs wiggle and in_valid pulses while the byte is in flight.
        send(1'b0, 8'hC5, 1'b1);
        send(1'b1, 8'h01, 1'b1);

        for (int i = 0; i < 16; i++) begin
            r = 1'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 2));
            send(r, d, 1'($urandom));
        end

        // Reset in the middle of the high-nibble enable pulse.
        accept(1'b0, 8'h01);
        in_valid = 1'b0;
        for (int n = 0; n < 100 && !lcd_en; n++) @(negedge clk);
        check("mid_reset_en_seen", int'(lcd_en), 1);
        @(posedge clk);
        #1;
        do_reset();
        send(1'b1, 8'h41, 1'b0);

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
